// File: rtl/cdb_bus_controller_pkg.sv
// Shared constants for the common-data-bus grant engine and the combo-side arbiters.
package cdb_bus_controller_pkg;

    // Select value that no requester ever owns; a bus showing it is idle.
    localparam logic [7:0] IDLE_ADDRESS = 8'hFF;

    // Number of common data buses driven by the controller.
    localparam int CDB_COUNT = 2;

    // Width of a requester index; never zero so a single-requester build still has a pointer.
    function automatic int ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/cdb_bus_controller_rr_finder.sv
// Circular first-set-bit finder: scans request bits starting at rr_ptr_i,
// skipping any bit set in mask_i, and reports the first eligible index.
module cdb_bus_controller_rr_finder
    import cdb_bus_controller_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] request_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    input  logic [NUM_REQ-1:0] mask_i,
    output logic [PTR_W-1:0]   idx_o,
    output logic               found_o
);

    logic [NUM_REQ-1:0] eligible;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_eligible
        assign eligible[gi] = request_i[gi] & ~mask_i[gi];
    end

    // Walk the ring from the farthest offset back to the pointer so the
    // last assignment that sticks is the eligible bit closest to rr_ptr_i.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int pos;
            pos = int'(rr_ptr_i) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (eligible[pos]) begin
                idx_o   = PTR_W'(pos);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_bus_controller.sv
// Round-robin grant engine for the two common data buses. Picks up to two
// requesters per cycle, routes them around stalled buses and registers the
// select addresses and the grant mask.
module cdb_bus_controller
    import cdb_bus_controller_pkg::*;
#(
    parameter int         NUM_REQ      = 4,
    parameter logic [7:0] BASE_ADDRESS = 8'h00
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            request,
    input  logic [CDB_COUNT-1:0]          stall,
    output logic [CDB_COUNT-1:0][7:0]     select,
    output logic [NUM_REQ-1:0]            granted
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    // The idle address must stay out of the requester address range.
    if (NUM_REQ < 1 || NUM_REQ > 16 || (int'(BASE_ADDRESS) + NUM_REQ - 1) >= 255) begin : g_bad_cfg
        $error("cdb_bus_controller: NUM_REQ/BASE_ADDRESS collide with IDLE_ADDRESS or out of range");
    end

    logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [CDB_COUNT-1:0][7:0]     select_q, select_d;
    logic [NUM_REQ-1:0]            granted_q, granted_d;

    logic [PTR_W-1:0]   idx_a, idx_b;
    logic               found_a, found_b;
    logic [NUM_REQ-1:0] mask_b;

    // Hit B is the next hit after A in ring order, so A is simply masked out.
    assign mask_b = NUM_REQ'(1) << idx_a;

    cdb_bus_controller_rr_finder #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_find_a (
        .request_i (request),
        .rr_ptr_i  (rr_ptr_q),
        .mask_i    ('0),
        .idx_o     (idx_a),
        .found_o   (found_a)
    );

    cdb_bus_controller_rr_finder #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_find_b (
        .request_i (request),
        .rr_ptr_i  (rr_ptr_q),
        .mask_i    (mask_b),
        .idx_o     (idx_b),
        .found_o   (found_b)
    );

    // Route hits onto free buses: A takes the lowest free bus, B only gets
    // bus 1 when both buses are free. The pointer follows the last grant.
    always_comb begin
        logic [PTR_W-1:0] last_idx;
        logic             any_grant;

        select_d  = {CDB_COUNT{IDLE_ADDRESS}};
        granted_d = '0;
        rr_ptr_d  = rr_ptr_q;
        last_idx  = idx_a;
        any_grant = 1'b0;

        if (!stall[0]) begin
            if (found_a) begin
                select_d[0]       = BASE_ADDRESS + 8'(idx_a);
                granted_d[idx_a]  = 1'b1;
                last_idx          = idx_a;
                any_grant         = 1'b1;
                if (!stall[1] && found_b) begin
                    select_d[1]       = BASE_ADDRESS + 8'(idx_b);
                    granted_d[idx_b]  = 1'b1;
                    last_idx          = idx_b;
                end
            end
        end else if (!stall[1] && found_a) begin
            select_d[1]      = BASE_ADDRESS + 8'(idx_a);
            granted_d[idx_a] = 1'b1;
            last_idx         = idx_a;
            any_grant        = 1'b1;
        end

        if (any_grant) begin
            rr_ptr_d = (last_idx == LAST_IDX) ? '0 : last_idx + 1'b1;
        end
    end

    // Output and pointer registers; reset forces both buses idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            select_q  <= {CDB_COUNT{IDLE_ADDRESS}};
            granted_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            select_q  <= select_d;
            granted_q <= granted_d;
        end
    end

    assign select  = select_q;
    assign granted = granted_q;

endmodule

// File: tb/tb_cdb_bus_controller.sv
// Scoreboard bench for cdb_bus_controller: the driver computes the expected
// bus selections from a ring-order model and queues them; the monitor pops
// one entry per clock and compares against the registered outputs.
module tb_cdb_bus_controller;

    localparam int         NR   = 4;
    localparam logic [7:0] BASE = 8'h40;
    localparam logic [7:0] IDLE = 8'hFF;

    typedef struct {
        logic [7:0]    s0;
        logic [7:0]    s1;
        logic [NR-1:0] g;
        int            id;
    } exp_t;

    logic              clock;
    logic              reset;
    logic [NR-1:0]     request;
    logic [1:0]        stall;
    logic [1:0][7:0]   select;
    logic [NR-1:0]     granted;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   m_ptr = 0;
    int   txn_id = 0;

    cdb_bus_controller #(
        .NUM_REQ      (NR),
        .BASE_ADDRESS (BASE)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .request (request),
        .stall   (stall),
        .select  (select),
        .granted (granted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs and queue what the outputs must show after the next edge.
    task automatic cyc(input bit rst, input logic [NR-1:0] req, input logic [1:0] st);
        exp_t e;
        int   hits[$];
        int   free[$];
        int   n;
        @(negedge clock);
        reset   = rst;
        request = req;
        stall   = st;
        e.s0 = IDLE;
        e.s1 = IDLE;
        e.g  = '0;
        e.id = txn_id;
        txn_id++;
        if (rst) begin
            m_ptr = 0;
        end else begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (req[i]) hits.push_back(i);
            end
            for (int b = 0; b < 2; b++) begin
                if (!st[b]) free.push_back(b);
            end
            n = (hits.size() < free.size()) ? hits.size() : free.size();
            for (int k = 0; k < n; k++) begin
                if (free[k] == 0) e.s0 = BASE + 8'(hits[k]);
                else              e.s1 = BASE + 8'(hits[k]);
                e.g[hits[k]] = 1'b1;
            end
            if (n > 0) m_ptr = (hits[n-1] + 1) % NR;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: one registered result per clock, compared just after the edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (select[0] !== e.s0 || select[1] !== e.s1 || granted !== e.g) begin
                tests_failed++;
                $display("FAIL txn%0d bus_pick: got s0=%h s1=%h g=%b, want s0=%h s1=%h g=%b",
                         e.id, select[0], select[1], granted, e.s0, e.s1, e.g);
            end else begin
                $display("[TB] txn%0d ok s0=%h s1=%h g=%b", e.id, select[0], select[1], granted);
            end
        end
    end

    initial begin
        reset   = 1'b1;
        request = '1;
        stall   = 2'b00;

        // Reset held with all requesting.
        repeat (3) cyc(1'b1, 4'b1111, 2'b00);
        // Rotation: (0,1), (2,3), ...
        repeat (6) cyc(1'b0, 4'b1111, 2'b00);
        // Single requester that drops after one cycle.
        cyc(1'b0, 4'b0100, 2'b00);
        repeat (2) cyc(1'b0, 4'b0000, 2'b00);
        // Stall routing.
        cyc(1'b0, 4'b0011, 2'b01);
        cyc(1'b0, 4'b1111, 2'b11);
        cyc(1'b0, 4'b0011, 2'b10);
        // Wrap-around: grant 2 alone moves the pointer to 3, then 1001.
        cyc(1'b0, 4'b0100, 2'b00);
        cyc(1'b0, 4'b1001, 2'b00);
        cyc(1'b0, 4'b1111, 2'b00);
        // Reset mid-stream.
        repeat (3) cyc(1'b0, 4'b1111, 2'b00);
        cyc(1'b1, 4'b1111, 2'b00);
        repeat (3) cyc(1'b0, 4'b1111, 2'b00);
        // Randomized traffic with occasional stalls and resets.
        for (int r = 0; r < 300; r++) begin
            logic [NR-1:0] rq;
            logic [1:0]    st;
            bit            rs;
            rq = NR'($urandom_range(0, 15));
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            rs = ($urandom_range(0, 39) == 0);
            cyc(rs, rq, st);
        end
        repeat (2) cyc(1'b0, 4'b0000, 2'b00);

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
            @(posedge clock);
            #2;
        end
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cdb_bus_controller.md
# cdb_bus_controller

Central grant engine for the two common data buses. Each execution combo raises `get_bus` when it holds a result. This block drives a registered 8-bit select address onto each bus. The combo whose arbiter address matches sees `bus_granted` and drives that bus for the cycle. Fairness across combos comes from round-robin pointer rotation, and each bus can be stalled independently by its consumer.

## Interface
- `NUM_REQ`, default 4: number of requesting combos, 1..16.
- `BASE_ADDRESS`, default 8'h00: address of requester 0. Requester i has address `BASE_ADDRESS + i`. `BASE_ADDRESS + NUM_REQ - 1` must be below 8'hFF; this is checked by elaboration assertion.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `request`  in  NUM_REQ  bit i is `get_bus` of requester i, level-sensitive.
- `stall`  in  2  bit b high means bus b must not be granted next cycle.
- `select`  out  2x8  registered address driven to `data_bus[b].select`. 8'hFF means idle.
- `granted`  out  NUM_REQ  registered one-hot-or-two-hot mask of the requesters selected this cycle.

## Operation
- State:
  - `rr_ptr` (clog2(NUM_REQ) bits).
  - `select[0..1]` registers.
  - `granted` register.
- Each cycle, combinational pick over the sampled `request`:
  - Scan the indices circularly starting at `rr_ptr`.
  - The first set bit is hit A; the second distinct set bit is hit B.
- Bus assignment for the next cycle:
  - Neither bus stalled: A goes to bus 0, B goes to bus 1.
  - Exactly one bus free: A goes to the free bus, B is not granted, and the stalled bus gets 8'hFF.
  - Both buses stalled: both get 8'hFF, `granted` is 0, and `rr_ptr` is unchanged.
  - Missing hits: a bus with no hit gets 8'hFF.
- Pointer update:
  - `rr_ptr` becomes (index of the last granted requester + 1) mod NUM_REQ.
  - With no grant, `rr_ptr` is unchanged.
- A requester is never placed on both buses in the same cycle.
- Requester obligation: when a requester observes its grant and has no further result, it drops `request` combinationally in that same cycle. Its request in the grant cycle is what gets sampled for the following selection.
- A requester that keeps `request` high after a grant remains eligible. The pointer has already moved past it, so other pending requesters are served first.
- Reset values:
  - `select[0]` = `select[1]` = 8'hFF.
  - `granted` = 0.
  - `rr_ptr` = 0.
- Reset asserted mid-operation overrides any pick. The outputs are idle in the cycle after the reset edge.

## Timing
- Latency of one cycle: `request`/`stall` are sampled at edge N, and `select`/`granted` are valid from edge N+1 until edge N+2.
- Each grant lasts exactly one cycle. The block never holds the same address across cycles unless it re-selects on a fresh request.
- No combinational path runs from any input to any output.
- `stall` affects only the selection registered at the next edge. It does not change the grant already on the bus.
- Throughput: up to 2 results per cycle. Worst-case wait for any continuously requesting combo is ceil(NUM_REQ/2) grant cycles when no bus is stalled.

## Structure
- Package `structures` gains:
  - `IDLE_ADDRESS = 8'hFF`.
  - `CDB_COUNT = 2`.
- The combo-side `arbiter` compares against `IDLE_ADDRESS` from the same package.
- Sub-module `rr_finder`:
  - Inputs: `request`, `rr_ptr`, mask.
  - Outputs: first-hit index and a found flag.
  - Instantiated twice: the second instance has A masked out.
- The top level holds the stall routing, the pointer and the output registers.

## Test plan
- **Reset:** hold `reset` with `request` = 4'b1111. `select` = {8'hFF, 8'hFF} and `granted` = 0 throughout. Release reset: the first selections are addr 0 on bus 0 and addr 1 on bus 1 one cycle later.
- **Rotation:** hold `request` = 4'b1111 with no stall. Successive cycles give the bus0/bus1 pairs (0,1), (2,3), (0,1), …, and `rr_ptr` alternates 2, 0.
- **Single requester with drop:** `request` = 4'b0100 for one cycle, then 0. Exactly one cycle has bus0 = 8'h02 and bus1 = 8'hFF; then both buses are idle.
- **Stall routing:**
  - `stall` = 2'b01 with `request` = 4'b0011: bus1 = addr 0, bus0 = 8'hFF, and `rr_ptr` becomes 1.
  - `stall` = 2'b11: both buses idle and `rr_ptr` is held.
- **Wrap-around:** with `rr_ptr` = 3 and `request` = 4'b1001, bus0 = addr 3 and bus1 = addr 0, and `rr_ptr` becomes 1.
- **Reset mid-stream:** assert `reset` during continuous traffic. Both selects are 8'hFF the next cycle, and the first post-reset pair restarts from index 0.
